// File: rtl/ring_onehot_decoder.sv
// rtl/ring_onehot_decoder.sv - one-hot ring sequence checker and phase decoder
// Optional saturating error counter enabled by defining RING_DECODE_ERRCNT_EN.
module ring_onehot_decoder #(
    parameter int N        = 8,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         I,
    input  logic                 CLR_ERR,
    output logic [$clog2(N)-1:0] O,
    output logic                 valid,
    output logic                 err,
    output logic                 err_sticky,
    output logic                 locked,
    output logic [ERR_W-1:0]     err_count
);
    localparam int OW = $clog2(N);
    localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  prev_q;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [OW-1:0] o_q, o_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          err_sticky_q, err_sticky_d;
    logic          onehot, step, violation;
    logic [OW-1:0] hot_idx;

    always_comb begin
        onehot = (I != '0) && ((I & (I - N'(1))) == '0);
        step   = onehot && (I == {prev_q[N-2:0], prev_q[N-1]});
    end

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (I[i]) hot_idx = OW'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        o_d          = o_q;
        valid_d      = valid_q;
        err_d        = err_q;
        err_sticky_d = err_sticky_q;
        violation    = 1'b0;
        if (CLR_ERR) err_sticky_d = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                err_d   = 1'b0;
                valid_d = 1'b0;
                if (step && (match_cnt_q == MATCH_LAST)) begin
                    state_d     = ST_LOCKED;
                    match_cnt_d = '0;
                    valid_d     = 1'b1;
                    o_d         = hot_idx;
                end else if (step) begin
                    match_cnt_d = match_cnt_q + MW'(1);
                end else begin
                    match_cnt_d = '0;
                end
            end
            default: begin
                if (step) begin
                    valid_d = 1'b1;
                    o_d     = hot_idx;
                    err_d   = 1'b0;
                end else begin
                    // A violation overrides a coincident CLR_ERR.
                    violation    = 1'b1;
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                    valid_d      = 1'b0;
                    match_cnt_d  = '0;
                    state_d      = ST_UNLOCKED;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_UNLOCKED;
            prev_q       <= '0;
            match_cnt_q  <= '0;
            o_q          <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= I;
            match_cnt_q  <= match_cnt_d;
            o_q          <= o_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef RING_DECODE_ERRCNT_EN
    logic [ERR_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (violation) begin
            if (CLR_ERR) err_count_d = ERR_W'(1);
            else if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
        end else if (CLR_ERR) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) err_count_q <= '0;
        else       err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    logic unused_violation;
    assign unused_violation = violation;
    assign err_count        = '0;
`endif

    assign O          = o_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign locked     = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_ring_onehot_decoder.sv
// tb/tb_ring_onehot_decoder.sv - directed self-checking bench for ring_onehot_decoder
module tb_ring_onehot_decoder;
`ifdef RING_DECODE_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] I = 8'h00;
    logic       CLR_ERR = 1'b0;
    logic [2:0] O;
    logic       valid, err, err_sticky, locked;
    logic [1:0] err_count;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    ring_onehot_decoder #(.N(8), .LOCK_CNT(2), .ERR_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .I(I), .CLR_ERR(CLR_ERR), .O(O), .valid(valid),
        .err(err), .err_sticky(err_sticky), .locked(locked), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic [7:0] v);
        I = v;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(8'h01);
        step(8'h02);
        RESET = 1'b0;
        checks++;
        if ({O, valid, err, err_sticky, locked, err_count} !== 9'b0) begin
            errors++;
            $display("FAIL reset: O=%0d valid=%b err=%b sticky=%b locked=%b cnt=%0d, want all 0",
                     O, valid, err, err_sticky, locked, err_count);
        end
    endtask

    task automatic test_lock();
        step(8'h01);
        step(8'h02);
        checks++;
        if (valid !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: valid=%b locked=%b want 0 0", valid, locked);
        end
        step(8'h04);
        checks++;
        if (valid !== 1'b1 || locked !== 1'b1 || O !== 3'd2) begin
            errors++;
            $display("FAIL lock_first: valid=%b locked=%b O=%0d want 1 1 2", valid, locked, O);
        end
        step(8'h08);
        checks++;
        if (valid !== 1'b1 || O !== 3'd3) begin
            errors++;
            $display("FAIL lock_next: valid=%b O=%0d want 1 3", valid, O);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] vecs [5];
        logic [2:0] exp_o [5];
        vecs  = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        exp_o = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int k = 0; k < 5; k++) begin
            step(vecs[k]);
            checks++;
            if (O !== exp_o[k] || valid !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL wrap[%0d]: O=%0d valid=%b err=%b want %0d 1 0", k, O, valid, err, exp_o[k]);
            end
        end
    endtask

    task automatic test_violation();
        step(8'h02);
        step(8'h04);
        step(8'h18);
        checks++;
        if (err !== 1'b1 || valid !== 1'b0 || locked !== 1'b0 || err_sticky !== 1'b1 ||
            err_count !== (CNT_EN ? 2'd1 : 2'd0) || O !== 3'd2) begin
            errors++;
            $display("FAIL violation: err=%b valid=%b locked=%b sticky=%b cnt=%0d O=%0d want 1 0 0 1 %0d 2",
                     err, valid, locked, err_sticky, err_count, O, CNT_EN ? 1 : 0);
        end
        step(8'h01);
        checks++;
        if (err !== 1'b0 || valid !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse: err=%b valid=%b sticky=%b want 0 0 1", err, valid, err_sticky);
        end
        step(8'h02);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: valid=%b want 0", valid);
        end
        step(8'h04);
        checks++;
        if (valid !== 1'b1 || locked !== 1'b1 || O !== 3'd2) begin
            errors++;
            $display("FAIL relock: valid=%b locked=%b O=%0d want 1 1 2", valid, locked, O);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        CLR_ERR = 1'b1;
        step(8'h08);
        CLR_ERR = 1'b0;
        checks++;
        if (err_count !== 2'd0 || err_sticky !== 1'b0 || valid !== 1'b1 || O !== 3'd3) begin
            errors++;
            $display("FAIL clear_pre: cnt=%0d sticky=%b valid=%b O=%0d want 0 0 1 3", err_count, err_sticky, valid, O);
        end
        err_pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            step(8'h00);
            if (err === 1'b1) err_pulses++;
            exp_cnt = CNT_EN ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
            checks++;
            if (err_count !== exp_cnt || err_sticky !== 1'b1 || err !== 1'b1) begin
                errors++;
                $display("FAIL sat[%0d]: cnt=%0d sticky=%b err=%b want %0d 1 1", k, err_count, err_sticky, err, exp_cnt);
            end
            step(8'h01);
            if (err === 1'b1) err_pulses++;
            step(8'h02);
            step(8'h04);
        end
        checks++;
        if (err_pulses !== 4 || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_pulses: pulses=%0d locked=%b want 4 1", err_pulses, locked);
        end
        CLR_ERR = 1'b1;
        step(8'h08);
        CLR_ERR = 1'b0;
        checks++;
        if (err_count !== 2'd0 || err_sticky !== 1'b0 || valid !== 1'b1 || O !== 3'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear: cnt=%0d sticky=%b valid=%b O=%0d err=%b want 0 0 1 3 0",
                     err_count, err_sticky, valid, O, err);
        end
        CLR_ERR = 1'b1;
        step(8'h00);
        CLR_ERR = 1'b0;
        checks++;
        if (err_count !== (CNT_EN ? 2'd1 : 2'd0) || err_sticky !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_violation: cnt=%0d sticky=%b err=%b want %0d 1 1",
                     err_count, err_sticky, err, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        step(8'h08);
        step(8'h10);
        step(8'h20);
        checks++;
        if (valid !== 1'b1 || O !== 3'd5) begin
            errors++;
            $display("FAIL pre_reset_lock: valid=%b O=%0d want 1 5", valid, O);
        end
        RESET = 1'b1;
        step(8'h40);
        RESET = 1'b0;
        checks++;
        if ({O, valid, err, err_sticky, locked, err_count} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid: O=%0d valid=%b err=%b sticky=%b locked=%b cnt=%0d, want all 0",
                     O, valid, err, err_sticky, locked, err_count);
        end
        step(8'h80);
        step(8'h01);
        checks++;
        if (valid !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_relock_early: valid=%b locked=%b want 0 0", valid, locked);
        end
        step(8'h02);
        checks++;
        if (valid !== 1'b1 || locked !== 1'b1 || O !== 3'd1) begin
            errors++;
            $display("FAIL reset_relock: valid=%b locked=%b O=%0d want 1 1 1", valid, locked, O);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_violation();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
